// File: rtl/lcd1602_pkg.sv
// Shared LCD1602 definitions: instruction codes, DDRAM line geometry and
// the address-counter stepping rule used by the bus monitor.
package lcd1602_pkg;

  // Instruction bytes issued by the driver blocks during bring-up and cursor moves
  localparam logic [7:0] INSTR_FUNC_SET   = 8'h38;
  localparam logic [7:0] INSTR_DISP_OFF   = 8'h08;
  localparam logic [7:0] INSTR_CLEAR      = 8'h01;
  localparam logic [7:0] INSTR_ENTRY_INC  = 8'h06;
  localparam logic [7:0] INSTR_DISP_ON    = 8'h0C;
  localparam logic [7:0] INSTR_CGRAM_BASE = 8'h40;
  localparam logic [7:0] INSTR_LINE1      = 8'h80;
  localparam logic [7:0] INSTR_LINE2      = 8'hC0;

  // DDRAM line layout: line 1 is 0x00..0x27, line 2 is 0x40..0x67
  localparam logic [6:0] ROW0_BASE = 7'h00;
  localparam logic [6:0] ROW1_BASE = 7'h40;
  localparam logic [6:0] LINE1_END = 7'h27;
  localparam logic [6:0] LINE2_END = 7'h67;

  localparam logic [7:0] BLANK_CHAR = 8'h20;
  localparam int         CLEAR_CELLS = 32;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } mon_state_t;

  // One synchronizer stage holds a full bus sample so RS/RW/D stay aligned with EN
  typedef struct packed {
    logic       rs;
    logic       rw;
    logic       en;
    logic [7:0] d;
  } bus_sample_t;

  // Next address counter value: CGRAM wraps 63<->0, DDRAM jumps between lines
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic cg, input logic inc);
    logic [6:0] nxt;
    logic [5:0] low;
    low = inc ? (ac[5:0] + 6'd1) : (ac[5:0] - 6'd1);
    if (cg) begin
      nxt = {1'b0, low};
    end else if (inc) begin
      if (ac == LINE1_END)      nxt = ROW1_BASE;
      else if (ac == LINE2_END) nxt = ROW0_BASE;
      else                      nxt = ac + 7'd1;
    end else begin
      if (ac == ROW0_BASE)      nxt = LINE2_END;
      else if (ac == ROW1_BASE) nxt = LINE1_END;
      else                      nxt = ac - 7'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lcd1602_bus_monitor_if.sv
// LCD1602 write bus as driven by the driver blocks (master) and observed by
// the monitor (slave).
interface lcd1602_bus_monitor_if;
  logic       LCD1602_RS;
  logic       LCD1602_RW;
  logic       LCD1602_EN;
  logic [7:0] LCD1602_D;

  modport master (output LCD1602_RS, output LCD1602_RW, output LCD1602_EN, output LCD1602_D);
  modport slave  (input  LCD1602_RS, input  LCD1602_RW, input  LCD1602_EN, input  LCD1602_D);
endinterface

// File: rtl/lcd1602_bus_sync.sv
// Bus front end: synchronizes RS/RW/EN/D as one word, measures EN-high time
// and turns each EN falling edge into a registered accept or reject pulse.
module lcd1602_bus_sync
  import lcd1602_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_EN_HIGH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs_i,
  input  logic       rw_i,
  input  logic       en_i,
  input  logic [7:0] d_i,
  output logic       accept_o,
  output logic       reject_o,
  output logic       rs_o,
  output logic [7:0] d_o
);

  localparam int CNT_W = $clog2(MIN_EN_HIGH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_EN_HIGH);

  bus_sample_t      sync_d [SYNC_STAGES];
  bus_sample_t      sync_q [SYNC_STAGES];
  bus_sample_t      last;
  logic             en_prev_d, en_prev_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             accept_d, accept_q;
  logic             reject_d, reject_q;
  logic             rs_d, rs_q;
  logic [7:0]       data_d, data_q;
  logic             fall;

  assign last = sync_q[SYNC_STAGES-1];

  // Shift the sample pipeline, count EN-high cycles and classify falling edges
  always_comb begin
    sync_d[0] = '{rs: rs_i, rw: rw_i, en: en_i, d: d_i};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    en_prev_d = last.en;
    fall      = en_prev_q & ~last.en;
    if (last.en) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    else         cnt_d = '0;
    accept_d = fall & ~last.rw & (cnt_q == CNT_MAX);
    reject_d = fall & ~last.rw & (cnt_q != CNT_MAX);
    rs_d     = last.rs;
    data_d   = last.d;
  end

  // Front-end registers; reset discards any strobe in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      en_prev_q <= 1'b0;
      cnt_q     <= '0;
      accept_q  <= 1'b0;
      reject_q  <= 1'b0;
      rs_q      <= 1'b0;
      data_q    <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      en_prev_q <= en_prev_d;
      cnt_q     <= cnt_d;
      accept_q  <= accept_d;
      reject_q  <= reject_d;
      rs_q      <= rs_d;
      data_q    <= data_d;
    end
  end

  assign accept_o = accept_q;
  assign reject_o = reject_q;
  assign rs_o     = rs_q;
  assign d_o      = data_q;

endmodule

// File: rtl/lcd1602_bus_monitor.sv
// LCD1602 bus monitor: decodes accepted strobes and keeps a shadow of the
// controller (visible DDRAM, CGRAM, address counter and mode flags).
module lcd1602_bus_monitor
  import lcd1602_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_EN_HIGH = 8
) (
  input  logic                  CLOCK,
  input  logic                  RST_n,
  lcd1602_bus_monitor_if.slave  bus,
  input  logic [4:0]            rd_pos,
  output logic [7:0]            rd_char,
  input  logic [5:0]            cg_pos,
  output logic [4:0]            cg_row,
  output logic                  oEvent,
  output logic                  oIsData,
  output logic [7:0]            oByte,
  output logic [6:0]            ac,
  output logic                  cg_mode,
  output logic                  disp_on,
  output logic                  cursor_on,
  output logic                  blink_on,
  output logic                  entry_inc,
  output logic                  entry_shift,
  output logic                  busy,
  output logic [7:0]            err_cnt
);

  logic       acc, rej, s_rs;
  logic [7:0] s_d;

  lcd1602_bus_sync #(.SYNC_STAGES(SYNC_STAGES), .MIN_EN_HIGH(MIN_EN_HIGH)) u_sync (
    .clk      (CLOCK),
    .rst_n    (RST_n),
    .rs_i     (bus.LCD1602_RS),
    .rw_i     (bus.LCD1602_RW),
    .en_i     (bus.LCD1602_EN),
    .d_i      (bus.LCD1602_D),
    .accept_o (acc),
    .reject_o (rej),
    .rs_o     (s_rs),
    .d_o      (s_d)
  );

  mon_state_t state_d, state_q;
  logic [4:0] clr_cnt_d, clr_cnt_q;
  logic [6:0] ac_d, ac_q;
  logic       cg_mode_d, cg_mode_q, busy_d, busy_q;
  logic       disp_on_d, disp_on_q, cursor_on_d, cursor_on_q, blink_on_d, blink_on_q;
  logic       entry_inc_d, entry_inc_q, entry_shift_d, entry_shift_q;
  logic       event_d, event_q, is_data_d, is_data_q;
  logic [7:0] byte_d, byte_q, err_cnt_d, err_cnt_q;
  logic       dd_we, cg_we;
  logic [4:0] dd_waddr;
  logic [7:0] dd_wdata;
  logic [5:0] cg_waddr;
  logic [4:0] cg_wdata;
  logic [7:0] ddram_q [32];
  logic [4:0] cgram_q [64];
  logic [7:0] rd_char_d, rd_char_q;
  logic [4:0] cg_row_d, cg_row_q;

  // Strobe decode and clear-fill sequencing; strobes arriving mid-fill are errors
  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    ac_d          = ac_q;
    cg_mode_d     = cg_mode_q;
    busy_d        = busy_q;
    disp_on_d     = disp_on_q;
    cursor_on_d   = cursor_on_q;
    blink_on_d    = blink_on_q;
    entry_inc_d   = entry_inc_q;
    entry_shift_d = entry_shift_q;
    event_d       = 1'b0;
    is_data_d     = is_data_q;
    byte_d        = byte_q;
    err_cnt_d     = err_cnt_q;
    dd_we         = 1'b0;
    dd_waddr      = clr_cnt_q;
    dd_wdata      = BLANK_CHAR;
    cg_we         = 1'b0;
    cg_waddr      = ac_q[5:0];
    cg_wdata      = s_d[4:0];
    if (rej && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    case (state_q)
      ST_CLEAR: begin
        dd_we     = 1'b1;
        clr_cnt_d = clr_cnt_q + 5'd1;
        if (clr_cnt_q == 5'(CLEAR_CELLS - 1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
        if (acc && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end
      default: begin
        if (acc) begin
          event_d   = 1'b1;
          is_data_d = s_rs;
          byte_d    = s_d;
          if (s_rs) begin
            if (cg_mode_q) begin
              cg_we = 1'b1;
            end else if (ac_q[5:4] == 2'b00) begin
              dd_we    = 1'b1;
              dd_waddr = {ac_q[6], ac_q[3:0]};
              dd_wdata = s_d;
            end
            ac_d = ac_step(ac_q, cg_mode_q, entry_inc_q);
          end else begin
            casez (s_d)
              8'b1???????: begin ac_d = s_d[6:0]; cg_mode_d = 1'b0; end
              8'b01??????: begin ac_d = {1'b0, s_d[5:0]}; cg_mode_d = 1'b1; end
              8'b0001????: if (!s_d[3]) ac_d = ac_step(ac_q, cg_mode_q, s_d[2]);
              8'b00001???: begin disp_on_d = s_d[2]; cursor_on_d = s_d[1]; blink_on_d = s_d[0]; end
              8'b000001??: begin entry_inc_d = s_d[1]; entry_shift_d = s_d[0]; end
              8'b0000001?: begin ac_d = '0; cg_mode_d = 1'b0; end
              8'b00000001: begin
                state_d     = ST_CLEAR;
                busy_d      = 1'b1;
                clr_cnt_d   = '0;
                ac_d        = '0;
                cg_mode_d   = 1'b0;
                entry_inc_d = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
    endcase
    rd_char_d = ddram_q[rd_pos];
    cg_row_d  = cgram_q[cg_pos];
  end

  // Control state, flags and registered event outputs
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      state_q       <= ST_IDLE;
      clr_cnt_q     <= '0;
      ac_q          <= '0;
      cg_mode_q     <= 1'b0;
      busy_q        <= 1'b0;
      disp_on_q     <= 1'b0;
      cursor_on_q   <= 1'b0;
      blink_on_q    <= 1'b0;
      entry_inc_q   <= 1'b1;
      entry_shift_q <= 1'b0;
      event_q       <= 1'b0;
      is_data_q     <= 1'b0;
      byte_q        <= '0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      ac_q          <= ac_d;
      cg_mode_q     <= cg_mode_d;
      busy_q        <= busy_d;
      disp_on_q     <= disp_on_d;
      cursor_on_q   <= cursor_on_d;
      blink_on_q    <= blink_on_d;
      entry_inc_q   <= entry_inc_d;
      entry_shift_q <= entry_shift_d;
      event_q       <= event_d;
      is_data_q     <= is_data_d;
      byte_q        <= byte_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  // Shadow RAMs with registered read ports; a same-cycle read sees the old cell
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < 32; i++) ddram_q[i] <= BLANK_CHAR;
      for (int i = 0; i < 64; i++) cgram_q[i] <= '0;
      rd_char_q <= BLANK_CHAR;
      cg_row_q  <= '0;
    end else begin
      if (dd_we) ddram_q[dd_waddr] <= dd_wdata;
      if (cg_we) cgram_q[cg_waddr] <= cg_wdata;
      rd_char_q <= rd_char_d;
      cg_row_q  <= cg_row_d;
    end
  end

  assign rd_char     = rd_char_q;
  assign cg_row      = cg_row_q;
  assign oEvent      = event_q;
  assign oIsData     = is_data_q;
  assign oByte       = byte_q;
  assign ac          = ac_q;
  assign cg_mode     = cg_mode_q;
  assign disp_on     = disp_on_q;
  assign cursor_on   = cursor_on_q;
  assign blink_on    = blink_on_q;
  assign entry_inc   = entry_inc_q;
  assign entry_shift = entry_shift_q;
  assign busy        = busy_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_lcd1602_bus_monitor.sv
// Directed bench for lcd1602_bus_monitor: table of instruction vectors plus
// hand-written sequences for CGRAM/DDRAM fills, line wrap, rejects and reset.
module tb_lcd1602_bus_monitor;
  import lcd1602_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int MIN_EN_HIGH = 8;
  localparam int EXP_LAT     = SYNC_STAGES + 2;

  logic       CLOCK = 1'b0;
  logic       RST_n;
  logic [4:0] rd_pos;
  logic [7:0] rd_char;
  logic [5:0] cg_pos;
  logic [4:0] cg_row;
  logic       oEvent, oIsData;
  logic [7:0] oByte;
  logic [6:0] ac;
  logic       cg_mode, disp_on, cursor_on, blink_on, entry_inc, entry_shift, busy;
  logic [7:0] err_cnt;

  lcd1602_bus_monitor_if bus_if ();

  lcd1602_bus_monitor #(.SYNC_STAGES(SYNC_STAGES), .MIN_EN_HIGH(MIN_EN_HIGH)) dut (
    .CLOCK(CLOCK), .RST_n(RST_n), .bus(bus_if), .rd_pos(rd_pos), .rd_char(rd_char),
    .cg_pos(cg_pos), .cg_row(cg_row), .oEvent(oEvent), .oIsData(oIsData), .oByte(oByte),
    .ac(ac), .cg_mode(cg_mode), .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .entry_inc(entry_inc), .entry_shift(entry_shift), .busy(busy), .err_cnt(err_cnt)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;
  int busy_cycles = 0;
  int busy_rise_evt = 0;
  bit busy_prev = 1'b0;

  // Count busy cycles and busy rises that coincide with an event pulse
  always @(negedge CLOCK) begin
    busy_prev <= busy;
    if (busy) busy_cycles <= busy_cycles + 1;
    if (busy && !busy_prev && oEvent) busy_rise_evt <= busy_rise_evt + 1;
  end

  typedef struct {
    logic       rs;
    logic [7:0] d;
    logic [6:0] exp_ac;
    logic       exp_cg;
    logic [4:0] exp_flags;
  } vec_t;

  vec_t       vecs [23];
  logic [7:0] exp_dd [32];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // One bus strobe; lat = posedges from the sampled EN fall to oEvent (0 = none)
  task automatic applyStimulus(input logic rs, input logic rw, input logic [7:0] d,
                               input int hi, output int lat);
    @(negedge CLOCK);
    bus_if.LCD1602_RS = rs;
    bus_if.LCD1602_RW = rw;
    bus_if.LCD1602_D  = d;
    @(negedge CLOCK);
    bus_if.LCD1602_EN = 1'b1;
    repeat (hi) @(negedge CLOCK);
    bus_if.LCD1602_EN = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge CLOCK);
      #1;
      if (oEvent && lat == 0) lat = k;
    end
  endtask

  task automatic readShadow(input logic [4:0] pos, output logic [7:0] v);
    @(negedge CLOCK);
    rd_pos = pos;
    @(posedge CLOCK);
    #1 v = rd_char;
  endtask

  task automatic readCg(input logic [5:0] pos, output logic [4:0] v);
    @(negedge CLOCK);
    cg_pos = pos;
    @(posedge CLOCK);
    #1 v = cg_row;
  endtask

  task automatic checkShadow(input string tag);
    logic [7:0] v;
    for (int i = 0; i < 32; i++) begin
      readShadow(5'(i), v);
      checkOutput($sformatf("%s_dd%0d", tag, i), 32'(v), 32'(exp_dd[i]));
    end
  endtask

  initial begin
    int lat;
    int b0, r0;
    logic [7:0] v8;
    logic [4:0] v5;

    vecs[0]  = '{1'b0, 8'h85, 7'h05, 1'b0, 5'b10010};
    vecs[1]  = '{1'b0, 8'h14, 7'h06, 1'b0, 5'b10010};
    vecs[2]  = '{1'b0, 8'h10, 7'h05, 1'b0, 5'b10010};
    vecs[3]  = '{1'b0, 8'h18, 7'h05, 1'b0, 5'b10010};
    vecs[4]  = '{1'b0, 8'h0F, 7'h05, 1'b0, 5'b11110};
    vecs[5]  = '{1'b0, 8'h05, 7'h05, 1'b0, 5'b11101};
    vecs[6]  = '{1'b0, 8'h07, 7'h05, 1'b0, 5'b11111};
    vecs[7]  = '{1'b0, 8'h06, 7'h05, 1'b0, 5'b11110};
    vecs[8]  = '{1'b0, 8'h0C, 7'h05, 1'b0, 5'b10010};
    vecs[9]  = '{1'b0, 8'h27, 7'h05, 1'b0, 5'b10010};
    vecs[10] = '{1'b0, 8'h00, 7'h05, 1'b0, 5'b10010};
    vecs[11] = '{1'b0, 8'h02, 7'h00, 1'b0, 5'b10010};
    vecs[12] = '{1'b0, 8'h10, 7'h67, 1'b0, 5'b10010};
    vecs[13] = '{1'b0, 8'h14, 7'h00, 1'b0, 5'b10010};
    vecs[14] = '{1'b0, 8'h4A, 7'h0A, 1'b1, 5'b10010};
    vecs[15] = '{1'b0, 8'h03, 7'h00, 1'b0, 5'b10010};
    vecs[16] = '{1'b0, 8'hA7, 7'h27, 1'b0, 5'b10010};
    vecs[17] = '{1'b0, 8'h14, 7'h40, 1'b0, 5'b10010};
    vecs[18] = '{1'b0, 8'h10, 7'h27, 1'b0, 5'b10010};
    vecs[19] = '{1'b0, 8'h40, 7'h00, 1'b1, 5'b10010};
    vecs[20] = '{1'b0, 8'h10, 7'h3F, 1'b1, 5'b10010};
    vecs[21] = '{1'b0, 8'h14, 7'h00, 1'b1, 5'b10010};
    vecs[22] = '{1'b0, 8'h80, 7'h00, 1'b0, 5'b10010};
    for (int i = 0; i < 32; i++) exp_dd[i] = 8'h20;

    RST_n = 1'b0;
    bus_if.LCD1602_RS = 1'b0;
    bus_if.LCD1602_RW = 1'b0;
    bus_if.LCD1602_EN = 1'b0;
    bus_if.LCD1602_D  = 8'h00;
    rd_pos = 5'd0;
    cg_pos = 6'd0;
    repeat (3) @(negedge CLOCK);
    RST_n = 1'b1;
    @(negedge CLOCK);

    $display("[TB] reset values");
    checkOutput("rst_rd_char", 32'(rd_char), 32'h20);
    checkOutput("rst_cg_row", 32'(cg_row), 32'h0);
    checkOutput("rst_ac", 32'(ac), 32'h0);
    checkOutput("rst_flags", 32'({cg_mode, disp_on, cursor_on, blink_on, entry_inc, entry_shift}), 32'b000010);
    checkOutput("rst_evt", 32'({oEvent, oIsData, oByte}), 32'h0);
    checkOutput("rst_busy_err", 32'({busy, err_cnt}), 32'h0);

    $display("[TB] init sequence");
    applyStimulus(1'b0, 1'b0, INSTR_FUNC_SET, 50, lat);
    checkOutput("init_func_lat", 32'(lat), 32'(EXP_LAT));
    checkOutput("init_func_byte", 32'({oIsData, oByte}), 32'h038);
    applyStimulus(1'b0, 1'b0, INSTR_DISP_OFF, 50, lat);
    b0 = busy_cycles;
    r0 = busy_rise_evt;
    applyStimulus(1'b0, 1'b0, INSTR_CLEAR, 50, lat);
    checkOutput("init_clear_lat", 32'(lat), 32'(EXP_LAT));
    repeat (40) @(posedge CLOCK);
    #1;
    checkOutput("init_busy_len", 32'(busy_cycles - b0), 32'd32);
    checkOutput("init_busy_rise", 32'(busy_rise_evt - r0), 32'd1);
    applyStimulus(1'b0, 1'b0, INSTR_ENTRY_INC, 50, lat);
    applyStimulus(1'b0, 1'b0, INSTR_DISP_ON, 50, lat);
    checkOutput("init_flags", 32'({disp_on, cursor_on, blink_on, entry_inc, entry_shift}), 32'b10010);
    checkOutput("init_ac", 32'(ac), 32'h0);

    $display("[TB] instruction vectors");
    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i].rs, 1'b0, vecs[i].d, 10, lat);
      checkOutput($sformatf("vec%0d_lat", i), 32'(lat), 32'(EXP_LAT));
      checkOutput($sformatf("vec%0d_byte", i), 32'({oIsData, oByte}), 32'({vecs[i].rs, vecs[i].d}));
      checkOutput($sformatf("vec%0d_ac", i), 32'({cg_mode, ac}), 32'({vecs[i].exp_cg, vecs[i].exp_ac}));
      checkOutput($sformatf("vec%0d_flags", i), 32'({disp_on, cursor_on, blink_on, entry_inc, entry_shift}),
                  32'(vecs[i].exp_flags));
    end

    $display("[TB] CGRAM fill");
    applyStimulus(1'b0, 1'b0, INSTR_CGRAM_BASE, 10, lat);
    for (int k = 0; k < 64; k++) applyStimulus(1'b1, 1'b0, 8'(k & 8'h1F), 10, lat);
    checkOutput("cg_ac_wrap", 32'({cg_mode, ac}), 32'h80);
    for (int k = 0; k < 64; k++) begin
      readCg(6'(k), v5);
      checkOutput($sformatf("cg_row%0d", k), 32'(v5), 32'(k & 8'h1F));
    end

    $display("[TB] DDRAM fill");
    applyStimulus(1'b0, 1'b0, INSTR_LINE1, 10, lat);
    for (int c = 0; c < 16; c++) applyStimulus(1'b1, 1'b0, 8'(8'h41 + c), 10, lat);
    applyStimulus(1'b0, 1'b0, INSTR_LINE2, 10, lat);
    for (int c = 0; c < 16; c++) applyStimulus(1'b1, 1'b0, 8'(8'h61 + c), 10, lat);
    checkOutput("dd_ac_final", 32'(ac), 32'h50);
    for (int c = 0; c < 16; c++) begin
      exp_dd[c]      = 8'(8'h41 + c);
      exp_dd[16 + c] = 8'(8'h61 + c);
    end
    readShadow(5'h05, v8);
    checkOutput("dd_pos05", 32'(v8), 32'h46);
    readShadow(5'h15, v8);
    checkOutput("dd_pos15", 32'(v8), 32'h66);
    checkShadow("fill");

    $display("[TB] line wrap");
    applyStimulus(1'b0, 1'b0, 8'hA7, 10, lat);
    applyStimulus(1'b1, 1'b0, 8'h58, 10, lat);
    checkOutput("wrap_inc_ac", 32'(ac), 32'h40);
    checkShadow("wrap");
    applyStimulus(1'b0, 1'b0, INSTR_LINE1, 10, lat);
    applyStimulus(1'b0, 1'b0, 8'h04, 10, lat);
    applyStimulus(1'b1, 1'b0, 8'h59, 10, lat);
    checkOutput("wrap_dec_ac", 32'(ac), 32'h67);
    readShadow(5'h00, v8);
    checkOutput("wrap_dec_cell0", 32'(v8), 32'h59);
    applyStimulus(1'b0, 1'b0, INSTR_ENTRY_INC, 10, lat);

    $display("[TB] rejected strobes");
    applyStimulus(1'b1, 1'b0, 8'h7A, 3, lat);
    checkOutput("short_no_evt", 32'(lat), 32'd0);
    checkOutput("short_err", 32'(err_cnt), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'h02, 10, lat);
    checkOutput("read_no_evt", 32'(lat), 32'd0);
    checkOutput("read_err", 32'(err_cnt), 32'd1);
    checkOutput("read_ac_kept", 32'(ac), 32'h67);
    applyStimulus(1'b0, 1'b0, 8'h02, MIN_EN_HIGH - 1, lat);
    checkOutput("len7_no_evt", 32'(lat), 32'd0);
    checkOutput("len7_err", 32'(err_cnt), 32'd2);
    applyStimulus(1'b0, 1'b0, 8'h02, MIN_EN_HIGH, lat);
    checkOutput("len8_lat", 32'(lat), 32'(EXP_LAT));
    checkOutput("len8_ac", 32'(ac), 32'h0);
    checkOutput("len8_err", 32'(err_cnt), 32'd2);
    applyStimulus(1'b0, 1'b0, INSTR_LINE2, 10, lat);
    b0 = busy_cycles;
    applyStimulus(1'b0, 1'b0, INSTR_CLEAR, 10, lat);
    checkOutput("clr_lat", 32'(lat), 32'(EXP_LAT));
    applyStimulus(1'b1, 1'b0, 8'h55, 10, lat);
    checkOutput("clr_drop_no_evt", 32'(lat), 32'd0);
    repeat (40) @(posedge CLOCK);
    #1;
    checkOutput("clr_drop_err", 32'(err_cnt), 32'd3);
    checkOutput("clr_busy_len", 32'(busy_cycles - b0), 32'd32);
    checkOutput("clr_ac", 32'({cg_mode, ac}), 32'h0);
    checkOutput("clr_byte", 32'({oIsData, oByte}), 32'h001);
    for (int i = 0; i < 32; i++) exp_dd[i] = 8'h20;
    checkShadow("clr");

    $display("[TB] reset during clear");
    applyStimulus(1'b0, 1'b0, INSTR_LINE1, 10, lat);
    for (int c = 0; c < 4; c++) applyStimulus(1'b1, 1'b0, 8'(8'h31 + c), 10, lat);
    applyStimulus(1'b0, 1'b0, 8'hC5, 10, lat);
    for (int c = 0; c < 4; c++) applyStimulus(1'b1, 1'b0, 8'(8'h35 + c), 10, lat);
    readShadow(5'h15, v8);
    checkOutput("pre_rst_cell21", 32'(v8), 32'h35);
    readCg(6'd5, v5);
    checkOutput("pre_rst_cg5", 32'(v5), 32'h05);
    @(negedge CLOCK);
    bus_if.LCD1602_RS = 1'b0;
    bus_if.LCD1602_RW = 1'b0;
    bus_if.LCD1602_D  = INSTR_CLEAR;
    @(negedge CLOCK);
    bus_if.LCD1602_EN = 1'b1;
    repeat (10) @(negedge CLOCK);
    bus_if.LCD1602_EN = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(posedge CLOCK);
      #1;
      if (busy) lat = k;
    end
    checkOutput("rst_clear_started", 32'(lat), 32'(EXP_LAT));
    repeat (10) @(posedge CLOCK);
    #1;
    RST_n = 1'b0;
    #1;
    checkOutput("midclr_busy_err", 32'({busy, err_cnt}), 32'h0);
    checkOutput("midclr_ac", 32'({cg_mode, ac}), 32'h0);
    checkOutput("midclr_flags", 32'({disp_on, cursor_on, blink_on, entry_inc, entry_shift}), 32'b00010);
    checkOutput("midclr_evt", 32'({oEvent, oIsData, oByte}), 32'h0);
    checkOutput("midclr_rd_char", 32'(rd_char), 32'h20);
    checkOutput("midclr_cg_row", 32'(cg_row), 32'h0);
    repeat (2) @(negedge CLOCK);
    RST_n = 1'b1;
    checkShadow("midclr");
    readCg(6'd5, v5);
    checkOutput("midclr_cg5", 32'(v5), 32'h0);
    readCg(6'd31, v5);
    checkOutput("midclr_cg31", 32'(v5), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
